pcie_sync_fifo_param: RTL

- Parametrised single-clock synchronous FIFO; successor to the fixed 8-bit FIFO in the transaction layer.
- Buffers TLP data words between transaction-layer producers and consumers.
- Generalised in data width and depth. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky error flags with clear, and optional first-word-fall-through (FWFT) mode.

---
 rtl/pcie_sync_fifo_param_if.sv | 33 +++
 rtl/pcie_sync_fifo_param.sv | 104 ++++++++++
 2 files changed

// File: rtl/pcie_sync_fifo_param_if.sv
// Handshake and status bundle between a transaction-layer client (master)
// and the parametrised synchronous FIFO (slave).
interface pcie_sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              wr;
   logic              rd;
   logic [DATA_W-1:0] data_in;
   logic              clr_err;
   logic [DATA_W-1:0] data_out;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_almost_full;
   logic              fifo_almost_empty;
   logic              fifo_overflow;
   logic              fifo_underflow;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      output wr, rd, data_in, clr_err,
      input  data_out, fifo_empty, fifo_full, fifo_almost_full,
             fifo_almost_empty, fifo_overflow, fifo_underflow, fifo_count
   );

   modport slave (
      input  wr, rd, data_in, clr_err,
      output data_out, fifo_empty, fifo_full, fifo_almost_full,
             fifo_almost_empty, fifo_overflow, fifo_underflow, fifo_count
   );
endinterface

// File: rtl/pcie_sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through; default is 1-cycle registered read.
module pcie_sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input logic                   clk,
   input logic                   rst,
   pcie_sync_fifo_param_if.slave bus
);
   localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_LVL   = AF_THRESH[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_LVL   = AE_THRESH[ADDR_W:0];

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rd_ok, wr_ok;

   // A write into a full FIFO still lands when the same cycle frees a slot.
   assign rd_ok = bus.rd & ~empty_q;
   assign wr_ok = bus.wr & (~full_q | rd_ok);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

      // Flags come from the next count so they are correct right after the edge.
      empty_d  = (count_d == '0);
      full_d   = (count_d == FULL_LVL);
      afull_d  = (count_d >= AF_LVL);
      aempty_d = (count_d <= AE_LVL);
      ovf_d    = (ovf_q & ~bus.clr_err) | (bus.wr & full_q & ~rd_ok);
      udf_d    = (udf_q & ~bus.clr_err) | (bus.rd & empty_q);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // NOTE: the storage array has no reset; stale contents are unreachable once the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) mem_q[wptr_q] <= bus.data_in;
   end

`ifdef FIFO_FWFT_EN
   // Head word is shown combinationally whenever something is stored.
   assign bus.data_out = empty_q ? '0 : mem_q[rptr_q];
`else
   logic [DATA_W-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= mem_q[rptr_q];
   end

   assign bus.data_out = dout_q;
`endif

   assign bus.fifo_empty        = empty_q;
   assign bus.fifo_full         = full_q;
   assign bus.fifo_almost_full  = afull_q;
   assign bus.fifo_almost_empty = aempty_q;
   assign bus.fifo_overflow     = ovf_q;
   assign bus.fifo_underflow    = udf_q;
   assign bus.fifo_count        = count_q;
endmodule
